// File: rtl/interleaver_loader.sv
// interleaver_loader: serial-to-parallel loader for 1056/6144-bit interleaver frames.
// Build macro LOADER_ABORT_EN adds the frame_abort input, which drops a frame while it is filling.
module interleaver_loader (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          bit_in,
    input  logic          bit_valid,
    input  logic          flag_long_in,
    input  logic          look_now,
`ifdef LOADER_ABORT_EN
    input  logic          frame_abort,
`endif
    output logic          bit_ready,
    output logic [6143:0] input_buffer,
    output logic          data_rdy,
    output logic          flag_long
);
    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
    state_t      state;
    logic [12:0] index;
    logic [12:0] last;
    // The final bit position comes from the latched frame size, never from the live select input.
    always_comb last = flag_long ? 13'd6143 : 13'd1055;
    // Frame FSM: the first bit clears the buffer, the last bit parks in HOLD until look_now arrives.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            index        <= '0;
            bit_ready    <= 1'b1;
            data_rdy     <= 1'b0;
            flag_long    <= 1'b0;
            input_buffer <= '0;
        end else begin
            case (state)
                IDLE: if (bit_valid) begin
                    input_buffer <= {6143'd0, bit_in};
                    flag_long    <= flag_long_in;
                    index        <= 13'd1;
                    state        <= FILL;
                end
                FILL:
`ifdef LOADER_ABORT_EN
                if (frame_abort) begin
                    state <= IDLE;
                    index <= '0;
                end else
`endif
                if (bit_valid) begin
                    input_buffer[index] <= bit_in;
                    if (index == last) begin
                        state     <= HOLD;
                        index     <= '0;
                        bit_ready <= 1'b0;
                        data_rdy  <= 1'b1;
                    end else begin
                        index <= index + 13'd1;
                    end
                end
                HOLD: if (look_now) begin
                    state     <= IDLE;
                    bit_ready <= 1'b1;
                    data_rdy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_interleaver_loader.sv
// tb_interleaver_loader: directed sequence of randomized frames checked against a bit-array reference.
module tb_interleaver_loader;
    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          flag_long_in = 1'b0;
    logic          look_now = 1'b0;
`ifdef LOADER_ABORT_EN
    logic          frame_abort = 1'b0;
`endif
    logic          bit_ready;
    logic [6143:0] input_buffer;
    logic          data_rdy;
    logic          flag_long;
    int            checks = 0;
    int            failures = 0;
    bit            frame_bits [6144];
    logic [6143:0] exp_buf;

    interleaver_loader dut (
        .clock(clock),
        .reset_n(reset_n),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .flag_long_in(flag_long_in),
        .look_now(look_now),
`ifdef LOADER_ABORT_EN
        .frame_abort(frame_abort),
`endif
        .bit_ready(bit_ready),
        .input_buffer(input_buffer),
        .data_rdy(data_rdy),
        .flag_long(flag_long)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkbuf(input string tag, input logic [6143:0] obs, input logic [6143:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed_low64=%h expected_low64=%h differing_bits=%0d",
                   tag, obs[63:0], exp[63:0], $countones(obs ^ exp));
        end
    endtask

    // mode 0: bit i is 1 when i%3==0; mode 1: random bits. Reference buffer holds bits [k-1:0], zero above.
    task automatic make_frame(input int k, input int mode);
        exp_buf = '0;
        for (int i = 0; i < 6144; i++) begin
            frame_bits[i] = (mode == 0) ? (i % 3 == 0) : 1'($urandom_range(0, 1));
            if (i < k) exp_buf[i] = frame_bits[i];
        end
    endtask

    // Presents n bits; gap drops bit_valid on every 4th cycle, toggle scrambles flag_long_in after bit 0.
    // look_now is randomly pulsed throughout, since it must be ignored while filling.
    task automatic send(input int n, input bit long_sel, input bit gap, input bit toggle);
        int i = 0;
        int cyc = 0;
        int early = 0;
        int notready = 0;
        int first_cyc = -1;
        while (i < n) begin
            bit_valid = !(gap && (cyc % 4 == 3));
            bit_in = frame_bits[i];
            look_now = 1'($urandom_range(0, 1));
            if (i == 0) flag_long_in = long_sel;
            else if (toggle) flag_long_in = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            cyc++;
            if (bit_valid) begin
                if (i == 0) begin
                    first_cyc = cyc;
                    chkbuf("first_bit_clears_buffer", input_buffer, {6143'd0, frame_bits[0]});
                end
                i++;
                if (i < n && data_rdy) early++;
            end
            if (i < n && !bit_ready) notready++;
        end
        bit_valid = 1'b0;
        look_now = 1'b0;
        chk("first_bit_accept_cycle", first_cyc, 1);
        chk("data_rdy_before_last_bit", early, 0);
        chk("bit_ready_low_in_fill", notready, 0);
    endtask

    task automatic check_done(input bit long_sel);
        chk("data_rdy_after_last", int'(data_rdy), 1);
        chk("bit_ready_in_hold", int'(bit_ready), 0);
        chk("flag_long_latched", int'(flag_long), int'(long_sel));
        chkbuf("frame_buffer", input_buffer, exp_buf);
    endtask

    // Sits in HOLD with noisy bit_valid, then releases with look_now.
    task automatic hold(input int n);
        int changed = 0;
        for (int c = 0; c < n; c++) begin
            bit_valid = 1'($urandom_range(0, 1));
            bit_in = 1'($urandom_range(0, 1));
            flag_long_in = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            if (input_buffer !== exp_buf || !data_rdy || bit_ready) changed++;
        end
        bit_valid = 1'b0;
        chk("hold_stable", changed, 0);
        look_now = 1'b1;
        @(posedge clock);
        #1;
        look_now = 1'b0;
        chk("data_rdy_low_after_look_now", int'(data_rdy), 0);
        chk("bit_ready_after_look_now", int'(bit_ready), 1);
        chkbuf("buffer_retained_in_idle", input_buffer, exp_buf);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_data_rdy"}, int'(data_rdy), 0);
        chk({tag, "_flag_long"}, int'(flag_long), 0);
        chk({tag, "_bit_ready"}, int'(bit_ready), 1);
        chkbuf({tag, "_buffer"}, input_buffer, '0);
    endtask

    initial begin
        #12;
        check_reset_values("reset");
        @(negedge clock);
        reset_n = 1'b1;
        look_now = 1'b1;
        @(posedge clock);
        #1;
        look_now = 1'b0;
        check_reset_values("idle_look_now");

        make_frame(1056, 0);
        send(1056, 1'b0, 1'b0, 1'b0);
        check_done(1'b0);
        hold(20);

        make_frame(6144, 1);
        send(6144, 1'b1, 1'b1, 1'b1);
        check_done(1'b1);
        hold(500);

        make_frame(1056, 1);
        send(1056, 1'b0, 1'b0, 1'b1);
        check_done(1'b0);
        hold(5);

        make_frame(1056, 1);
        send(700, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("reset_mid_frame");
        @(negedge clock);
        reset_n = 1'b1;
        make_frame(1056, 1);
        send(1056, 1'b0, 1'b1, 1'b0);
        check_done(1'b0);
        hold(3);

`ifdef LOADER_ABORT_EN
        make_frame(1056, 1);
        send(300, 1'b0, 1'b0, 1'b0);
        frame_abort = 1'b1;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        @(posedge clock);
        #1;
        frame_abort = 1'b0;
        bit_valid = 1'b0;
        chk("abort_data_rdy", int'(data_rdy), 0);
        chk("abort_bit_ready", int'(bit_ready), 1);
        make_frame(1056, 0);
        send(1056, 1'b0, 1'b0, 1'b0);
        check_done(1'b0);
        hold(3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interleaver_loader.md
INTERLEAVER_LOADER -- requirements
Module: interleaver_loader

Interface
REQ-001 Parameters: none; frame sizes fixed at K=1056 (short) and K=6144 (long).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 bit_in  input  1  serial frame bit, valid when bit_valid=1.
REQ-005 bit_valid  input  1  upstream bit strobe; a bit is accepted on a clock edge where bit_valid=1 and bit_ready=1.
REQ-006 flag_long_in  input  1  frame-size select, sampled with the first accepted bit of a frame (1=6144, 0=1056).
REQ-007 look_now  input  1  completion pulse from the downstream interleaver stage.
REQ-008 bit_ready  output  1  loader can accept a bit this cycle.
REQ-009 input_buffer  output  6144  parallel frame; bit i of frame at input_buffer[i].
REQ-010 data_rdy  output  1  frame complete; buffer and flag_long stable while high.
REQ-011 flag_long  output  1  latched frame-size select for the current frame.
REQ-012 frame_abort  input  1  present only when LOADER_ABORT_EN is defined (REQ-030).

Function
REQ-013 FSM states SHALL be IDLE, FILL, HOLD; encoding free.
REQ-014 bit_ready SHALL be 1 in IDLE and FILL, 0 in HOLD; data_rdy SHALL be 1 exactly in HOLD (registered, no combinational path from inputs).
REQ-015 IDLE: on accepted bit -> FILL; same edge: input_buffer cleared to all zero except [0]=bit_in, flag_long<=flag_long_in, index<=1.
REQ-016 FILL: each accepted bit SHALL be written to input_buffer[index], index incremented by 1; cycles with bit_valid=0 SHALL leave all state unchanged.
REQ-017 index SHALL be 13 bits; K SHALL be derived from the latched flag_long, never from flag_long_in after the first bit.
REQ-018 Acceptance of bit K-1 SHALL move FSM to HOLD; data_rdy SHALL be high in the cycle after that edge (latency 1 clock from last bit).
REQ-019 Short frame: input_buffer[6143:1056] SHALL read zero throughout FILL and HOLD.
REQ-020 HOLD: input_buffer, flag_long SHALL not change; bit_valid ignored.
REQ-021 HOLD and look_now=1 -> IDLE on that edge; data_rdy low in the following cycle; input_buffer retains contents until the next frame's first bit.
REQ-022 look_now in IDLE or FILL SHALL be ignored.
REQ-023 data_rdy SHALL deassert for at least one cycle between consecutive frames (downstream counter restart).
REQ-024 Back-to-back: a bit presented in the cycle after leaving HOLD SHALL be accepted as bit 0 of the next frame.
REQ-025 index SHALL never exceed K-1; no write outside [K-1:0].

Reset
REQ-026 reset_n=0 SHALL immediately force: FSM=IDLE, index=0, bit_ready=1 after reset release, data_rdy=0, flag_long=0, input_buffer=all zero.
REQ-027 Reset during FILL or HOLD SHALL discard the partial/complete frame; no data_rdy pulse results.
REQ-028 First accepted bit after reset release SHALL be bit 0 of a new frame.

Configuration
REQ-029 Macro LOADER_ABORT_EN selects frame-abort support.
REQ-030 Defined: frame_abort=1 in FILL SHALL return FSM to IDLE next edge, index=0, bit in same cycle dropped; frame_abort ignored in IDLE/HOLD; data_rdy never asserted for aborted frame.
REQ-031 Undefined: no frame_abort port; FILL exits only via REQ-018 or reset.

Verification
REQ-032 Short frame: flag_long_in=0, 1056 bits pattern i%3==0 -> data_rdy high 1 cycle after bit 1055, flag_long=0, buffer matches, [6143:1056]=0.
REQ-033 Long frame with bit_valid gaps (1 of every 4 cycles low), 6144 random bits -> buffer exact, data_rdy after bit 6143 only, bit_ready=0 in HOLD.
REQ-034 flag_long_in toggled mid-frame after first bit=1 -> still 6144 bits collected, flag_long=1.
REQ-035 HOLD for 500 cycles then look_now pulse -> data_rdy low next cycle; next frame bit 0 accepted immediately; buffer stable during HOLD.
REQ-036 reset_n low at bit 700 of short frame -> outputs at reset values; new 1056-bit frame completes normally.
REQ-037 LOADER_ABORT_EN defined: frame_abort at bit 300 -> no data_rdy; following full short frame loads correctly.
